// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//
// Shares one external combinational W-bit adder (sum + carry-out) between two
// requesters. A round-robin arbiter picks a requester, its operand pair is
// staged into registers that drive the shared adder, and the adder result is
// captured one cycle later and presented on a valid/ready response port along
// with the ID of the requester that owns it.
//
// Optional feature (macro ADDER_ARB_STATS_EN):
//   When defined, per-requester saturating grant counters are added and exposed
//   on grant_cnt0 / grant_cnt1. When undefined, those ports and counters are
//   absent and all other behaviour is identical.
//
// Parameters
//   W       operand / sum width in bits
//   CNT_W   grant-counter width (only used with ADDER_ARB_STATS_EN)
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req0_valid/ready/a/b        requester 0 operand handshake
//   req1_valid/ready/a/b        requester 1 operand handshake
//   add_a, add_b                registered operands to the shared adder
//   add_sum, add_cout           combinational result from the shared adder
//   rsp_valid/ready             result handshake towards the consumer
//   rsp_sum, rsp_cout, rsp_id   captured result and owning requester
//   grant_cnt0, grant_cnt1      saturating grant counters (stats build only)
// ---------------------------------------------------------------------------
module adder_share_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    input  logic [W-1:0]     add_sum,
    input  logic             add_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    logic   last;      // requester granted most recently
    logic   id_p0;     // owner of the operands currently on add_a/add_b

    logic accept_win;
    logic grant0;
    logic grant1;
    logic accept;

    // A new pair may be taken when idle, or when the held result drains in the
    // same cycle so back-to-back operations cost only two cycles each.
    assign accept_win = (state == IDLE) || ((state == DONE) && rsp_ready);

    // Round-robin: a lone requester always wins; on contention the one that
    // did not win last time goes. last resets to 1 so req0 wins first.
    assign grant0 = req0_valid && (!req1_valid || last);
    assign grant1 = req1_valid && (!req0_valid || !last);

    assign req0_ready = accept_win && grant0;
    assign req1_ready = accept_win && grant1;
    assign accept     = req0_ready || req1_ready;

    assign rsp_valid  = (state == DONE);

    // Operand staging -> adder -> result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            id_p0    <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        add_a <= req1_ready ? req1_a : req0_a;
                        add_b <= req1_ready ? req1_b : req0_b;
                        id_p0 <= req1_ready;
                        last  <= req1_ready;
                        state <= ISSUE;
                    end else if (state == DONE && rsp_ready) begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    // add_a/add_b have been stable for a full cycle, so the
                    // external adder output is settled here.
                    rsp_sum  <= add_sum;
                    rsp_cout <= add_cout;
                    rsp_id   <= id_p0;
                    state    <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready) grant_cnt0 <= sat_inc(grant_cnt0);
            if (req1_ready) grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic             req0_ready;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W-1:0]     add_sum;
    logic             add_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
    logic             rsp_id;
`ifdef ADDER_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
`endif

    adder_share_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id)
`ifdef ADDER_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // The shared external adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed response handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got sum=%0d id=%0d, expected no response", rsp_sum, rsp_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("rsp_sum",  rsp_sum,  e.sum);
                check_eq("rsp_cout", rsp_cout, e.cout);
                check_eq("rsp_id",   rsp_id,   e.id);
            end
        end
    end

    // Present one pair on requester id and wait (bounded) for its accept.
    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] esum, input logic ecout, output int lat);
        int got;
        exp_t e;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        got = 0;
        lat = -1;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) == 1'b1) begin
                got = 1;
                lat = i;
            end
        end
        check_eq(id ? "req1_accept" : "req0_accept", got, 1);
        if (got != 0) begin
            e.sum = esum; e.cout = ecout; e.id = id;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic push_exp(input logic [W-1:0] s, input logic c, input logic id);
        exp_t e;
        e.sum = s; e.cout = c; e.id = id;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   nacc;
        int   found;
        logic expid;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_add_a",     add_a,     0);
        check_eq("reset_add_b",     add_b,     0);
        check_eq("reset_rsp_sum",   rsp_sum,   0);
        check_eq("reset_rsp_id",    rsp_id,    0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // 3 + 4: accepted immediately, response two cycles after accept
        issue(1'b0, 4'h3, 4'h4, 4'h7, 1'b0, lat);
        check_eq("t1_ready_same_cycle", lat, 0);
        @(negedge clk);
        check_eq("t1_valid_at_t1", rsp_valid, 0);
        @(negedge clk);
        check_eq("t1_valid_at_t2", rsp_valid, 1);
        drain();

        // F + 1 on requester 1: wraps to 0 with carry out
        issue(1'b1, 4'hF, 4'h1, 4'h0, 1'b1, lat);
        drain();

        // Both requesters continuously valid: grants alternate, one per 2 cycles
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2;
        req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'h6;
        expid = 1'b0;
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("rr_not_both_ready", int'(req0_ready & req1_ready), 0);
            if (req0_ready || req1_ready) begin
                check_eq("rr_grant_id", req1_ready, expid);
                if (expid) push_exp(4'hB, 1'b0, 1'b1);
                else       push_exp(4'h3, 1'b0, 1'b0);
                expid = ~expid;
                nacc++;
            end
        end
        check_eq("rr_accept_count", nacc, 4);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Consumer stall: result held, no new accepts; release grants req1
        rsp_ready = 1'b0;
        issue(1'b0, 4'h9, 4'h9, 4'h2, 1'b1, lat);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1;
        end
        check_eq("stall_rsp_valid_seen", found, 1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1;
        req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("stall_rsp_valid", rsp_valid, 1);
            check_eq("stall_rsp_sum",   rsp_sum,   2);
            check_eq("stall_rsp_cout",  rsp_cout,  1);
            check_eq("stall_rsp_id",    rsp_id,    0);
            check_eq("stall_req0_ready", req0_ready, 0);
            check_eq("stall_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("release_req1_ready", req1_ready, 1);
        check_eq("release_req0_ready", req0_ready, 0);
        if (req1_ready) push_exp(4'hF, 1'b0, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Reset while an operation is in ISSUE: dropped, req0 wins afterwards
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3;
        @(negedge clk);
        check_eq("t5_req0_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_rsp_valid", rsp_valid, 0);
        check_eq("t5_rst_add_a",     add_a,     0);
        check_eq("t5_rst_rsp_sum",   rsp_sum,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_after_rst_valid", rsp_valid, 0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'h4; req0_b = 4'h5;
        req1_valid = 1'b1; req1_a = 4'h6; req1_b = 4'h6;
        @(negedge clk);
        check_eq("t5_req0_wins", req0_ready, 1);
        check_eq("t5_req1_loses", req1_ready, 0);
        if (req0_ready) push_exp(4'h9, 1'b0, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

`ifdef ADDER_ARB_STATS_EN
        // Saturating grant counters (CNT_W = 2 saturates at 3)
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_eq("stats_reset_cnt0", grant_cnt0, 0);
        check_eq("stats_reset_cnt1", grant_cnt1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            issue(1'b0, 4'h1, 4'h1, 4'h2, 1'b0, lat);
            if (k == 1) check_eq("stats_cnt0_two", grant_cnt0, 2);
        end
        check_eq("stats_cnt0_sat", grant_cnt0, 3);
        check_eq("stats_cnt1_zero", grant_cnt1, 0);
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
